// File: rtl/fifo_wr_arb.sv
// Round-robin write-side arbiter for a shared FIFO write port.
// Grants one producer at a time for a bounded burst and throttles on almost_full / wr_rst_busy.
module fifo_wr_arb #(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int BURST_LEN = 16
) (
    input  logic                   wr_clk,
    input  logic                   rst,
    input  logic                   wr_rst_busy,
    input  logic                   almost_full,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DW-1:0]    req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       data_ack,
    output logic                   fifo_wr_en,
    output logic [DW-1:0]          fifo_wr_data,
    output logic                   busy
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   ptr_r;
    logic [CW-1:0]   cnt_r;

    logic            stall_s;
    logic            sel_found_s;
    logic [PW-1:0]   sel_s;
    logic [DW-1:0]   own_data_s;
    logic            own_req_s;
    logic            own_last_s;
    logic            ack_any_s;
    logic            last_word_s;

    function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
        onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign stall_s     = almost_full | wr_rst_busy;
    assign data_ack    = grant & req & {N_REQ{~stall_s}};
    assign ack_any_s   = |data_ack;
    assign last_word_s = (cnt_r == CW'(BURST_LEN - 1)) | own_last_s;

    // Round-robin search: first requester strictly after ptr_r, wrapping.
    always_comb begin : rr_search
        int idx_v;
        logic [PW-1:0] idx_s;
        sel_s       = ptr_r;
        sel_found_s = 1'b0;
        idx_v       = 0;
        idx_s       = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx_v = (int'(ptr_r) + i) % N_REQ;
            idx_s = PW'(idx_v);
            if (!sel_found_s && req[idx_s]) begin
                sel_found_s = 1'b1;
                sel_s       = idx_s;
            end else begin
                sel_found_s = sel_found_s;
                sel_s       = sel_s;
            end
        end
    end

    // Data, request and last flag of the current burst owner.
    always_comb begin
        own_data_s = '0;
        own_req_s  = |(grant & req);
        own_last_s = |(grant & req_last);
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                own_data_s = req_data[i*DW +: DW];
            end else begin
                own_data_s = own_data_s;
            end
        end
    end

    // Arbitration state machine with registered FIFO write side.
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state_r      <= IDLE;
            grant        <= '0;
            busy         <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            cnt_r        <= '0;
            ptr_r        <= PW'(N_REQ - 1);
        end else begin
            case (state_r)
                IDLE: begin
                    fifo_wr_en <= 1'b0;
                    if (!wr_rst_busy && sel_found_s) begin
                        grant   <= onehot(sel_s);
                        ptr_r   <= sel_s;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= BURST;
                    end else begin
                        grant   <= '0;
                        busy    <= 1'b0;
                    end
                end
                BURST: begin
                    if (ack_any_s) begin
                        fifo_wr_en   <= 1'b1;
                        fifo_wr_data <= own_data_s;
                        cnt_r        <= cnt_r + CW'(1);
                        if (last_word_s) begin
                            grant   <= '0;
                            busy    <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            state_r <= BURST;
                        end
                    end else begin
                        fifo_wr_en <= 1'b0;
                        // A stall freezes the burst; a dropped request ends it.
                        if (!stall_s && !own_req_s) begin
                            grant   <= '0;
                            busy    <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            state_r <= BURST;
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    grant      <= '0;
                    busy       <= 1'b0;
                    fifo_wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: producer queues drive requests, a reference model
// predicts grants/acks and queues expected FIFO writes for a separate monitor.
module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 16;

    logic              wr_clk = 1'b0;
    logic              rst;
    logic              wr_rst_busy;
    logic              almost_full;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      grant;
    logic [N-1:0]      data_ack;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_wr_data;
    logic              busy;

    fifo_wr_arb #(.N_REQ(N), .DW(DW), .BURST_LEN(BL)) dut (
        .wr_clk(wr_clk), .rst(rst), .wr_rst_busy(wr_rst_busy), .almost_full(almost_full),
        .req(req), .req_data(req_data), .req_last(req_last), .grant(grant),
        .data_ack(data_ack), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .busy(busy)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } wr_t;

    logic [DW:0] pq [N][$];   // per-producer pending words, bit DW = last flag
    wr_t         sb [$];      // expected FIFO writes, stamped with the cycle they must appear
    int m_owner, m_ptr, m_cnt;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int drop_pct = 0;
    bit mon_en = 1'b0;
    bit rst_prev = 1'b1;
    logic [DW-1:0] mon_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic fill(input int i, input int n, input bit counting, input int last_pct);
        logic [DW-1:0] d;
        logic          l;
        for (int k = 0; k < n; k++) begin
            d = counting ? DW'(k) : DW'($urandom);
            l = ($urandom_range(99) < last_pct);
            pq[i].push_back({l, d});
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit do_rst, input bit wrb, input bit af);
        logic [N-1:0] r;
        logic [N-1:0] exp_ack;
        logic [N-1:0] exp_grant;
        logic [DW:0]  w;
        bit           stl;
        bit           found;
        int           idx;
        @(posedge wr_clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++) begin
            r[i] = (pq[i].size() > 0) && ($urandom_range(99) >= drop_pct);
            w = (pq[i].size() > 0) ? pq[i][0] : {1'b0, DW'($urandom)};
            req_data[i*DW +: DW] = w[DW-1:0];
            req_last[i] = w[DW];
        end
        req = r;
        rst = do_rst;
        wr_rst_busy = wrb;
        almost_full = af;
        stl = af | wrb;
        exp_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        exp_ack = (m_owner >= 0 && r[m_owner] && !stl) ? exp_grant : '0;
        @(negedge wr_clk);
        check("grant", 32'(grant), 32'(exp_grant));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("data_ack", 32'(data_ack), 32'(exp_ack));
        w = '0;
        if (exp_ack != '0) begin
            w = pq[m_owner].pop_front();
            if (!do_rst) sb.push_back('{cyc + 1, w[DW-1:0]});
            m_cnt++;
        end
        if (do_rst) begin
            m_owner = -1;
            m_ptr   = N - 1;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            if (!wrb && (r != '0)) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!found && r[idx]) begin
                        found   = 1'b1;
                        m_owner = idx;
                    end
                end
                m_ptr = m_owner;
                m_cnt = 0;
            end
        end else if (exp_ack != '0) begin
            if (m_cnt == BL || w[DW]) m_owner = -1;
        end else if (!stl && !r[m_owner]) begin
            m_owner = -1;
        end
    endtask

    task automatic run(input int n);
        for (int t = 0; t < n; t++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_until(input int owner, input int cnt, input int budget);
        int t = 0;
        while (!(m_owner == owner && m_cnt == cnt) && t < budget) begin
            step(1'b0, 1'b0, 1'b0);
            t++;
        end
        check("reach_word", 32'(t < budget), 32'd1);
    endtask

    // Monitor: every cycle the FIFO write side must match the scoreboard head.
    always @(negedge wr_clk) begin
        bit exp_en;
        if (mon_en) begin
            if (rst_prev) mon_data = '0;
            exp_en = (sb.size() > 0) && (sb[0].cyc == cyc);
            check("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_en));
            if (exp_en) begin
                mon_data = sb[0].data;
                void'(sb.pop_front());
            end
            check("fifo_wr_data", 32'(fifo_wr_data), 32'(mon_data));
            rst_prev = rst;
        end
    end

    initial begin
        rst = 1'b1; wr_rst_busy = 1'b0; almost_full = 1'b0;
        req = '0; req_data = '0; req_last = '0;
        m_owner = -1; m_ptr = N - 1; m_cnt = 0;
        repeat (2) @(posedge wr_clk);
        mon_en = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        // Write-reset window with requester 1 waiting
        fill(1, 30, 1'b0, 0);
        for (int t = 0; t < 20; t++) step(1'b0, 1'b1, 1'b0);
        run(40);

        // Requester 0 alone, values 0..15 twice
        fill(0, 16, 1'b1, 0);
        fill(0, 16, 1'b1, 0);
        run(40);

        // All four requesters continuously
        for (int i = 0; i < N; i++) fill(i, 32, 1'b0, 0);
        run(150);

        // almost_full for 5 cycles after the 6th word
        fill(0, 16, 1'b0, 0);
        run_until(0, 6, 30);
        for (int t = 0; t < 5; t++) step(1'b0, 1'b0, 1'b1);
        run(20);

        // req_last on requester 2's 3rd word while 3 also requests
        fill(2, 2, 1'b0, 0);
        pq[2].push_back({1'b1, 8'hA2});
        fill(2, 5, 1'b0, 0);
        fill(3, 20, 1'b0, 0);
        run(60);

        // Reset in the middle of a requester 3 burst
        fill(3, 20, 1'b0, 0);
        run_until(3, 8, 40);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) fill(i, 10, 1'b0, 0);
        run(80);

        // Randomized traffic with stalls, drops, last flags and occasional reset
        drop_pct = 5;
        for (int t = 0; t < 2000; t++) begin
            for (int i = 0; i < N; i++)
                if (pq[i].size() == 0 && $urandom_range(99) < 10)
                    fill(i, $urandom_range(40, 1), 1'b0, 10);
            step($urandom_range(499) == 0, $urandom_range(99) < 3, $urandom_range(99) < 15);
        end
        drop_pct = 0;
        run(400);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
